led_frame_arbiter: RTL and testbench
====================================

// Module: led_frame_arbiter
// PURPOSE
//  Shares the 64-bit 8x8 LED frame (feeds led_place_8x8_manager i_led_data) between N_REQ clients
//  (keypad echo, game logic, test pattern). Round-robin arbitration; owner writes rows in a burst
//  into a shadow buffer. The frame is swapped atomically on the last beat, so the matrix never shows a torn frame.
// PARAMETERS
//  N_REQ       3   number of requesting clients (2..8)
//  MAX_BEATS   16  beats allowed per burst before forced abort (>=8)
//  GAP_CYCLES  2   idle cycles after commit/abort before re-arbitration (>=1)
// PORTS
//  aclk            in   1         system clock; single clock domain
//  areset          in   1         synchronous reset, active-high
//  i_req           in   N_REQ     per-client request; held for the whole burst
//  i_row_addr      in   3*N_REQ   client k row index at [3k+2:3k]
//  i_row_data      in   8*N_REQ   client k row bits at [8k+7:8k]
//  i_last          in   N_REQ     marks final beat of client k burst
//  o_gnt           out  N_REQ     one-hot registered grant; beat = o_gnt[k] & i_req[k]
//  o_owner         out  OWNER_W   index of last granted client, OWNER_W = max(1,$clog2(N_REQ))
//  o_led_data      out  64        live frame; row r at [8r+7:8r]
//  o_frame_update  out  1         1-cycle pulse after a commit
//  o_abort         out  1         1-cycle pulse when a burst is discarded
// BEHAVIOUR
//  Reset: o_led_data=0, shadow=0, o_gnt=0, o_frame_update=0, o_abort=0, o_owner=N_REQ-1, state IDLE,
//   beat count=0, gap count=0. Client 0 therefore wins first arbitration. Reset mid-burst drops everything; frame cleared.
//  States: IDLE -> GRANT -> COMMIT|ABORT -> GAP -> IDLE.
//  IDLE: on the edge where i_req!=0, pick first set bit scanning o_owner+1, o_owner+2 ... (wrap mod N_REQ).
//   On that edge: o_gnt[win]<=1, o_owner<=win, state<=GRANT. Grant latency = 1 cycle after i_req seen.
//  GRANT: each beat edge writes shadow[8*addr+:8] <= client row data; beat count +1.
//   - beat with i_last[owner]: o_gnt<=0, state<=COMMIT.
//   - i_req[owner]=0 (dropped without last): o_gnt<=0, state<=ABORT.
//   - beat count reaches MAX_BEATS without i_last: that beat is written, then o_gnt<=0, state<=ABORT.
//   - Other clients' requests are ignored until IDLE; their o_gnt stays 0.
//   - Repeated row address within a burst: last write wins.
//  COMMIT: o_led_data<=shadow (includes last-beat row), o_frame_update<=1 for one cycle, state<=GAP.
//  ABORT: shadow<=o_led_data (partial writes discarded), o_abort<=1 for one cycle, state<=GAP.
//  GAP: GAP_CYCLES cycles with o_gnt=0, then IDLE. Beat count cleared on entry to GRANT.
//  Rows not written in a burst keep their previous frame value (shadow is persistent).
//  o_gnt is never multi-hot; o_led_data changes only on a COMMIT edge or reset.
//  Req to frame-visible latency for a B-beat burst with no stalls: 1 + B + 1 cycles.
// TESTING
//  1 reset; client0 req, rows 0..7 = 8'hA5, i_last on row 7 -> o_gnt[0] 1 cycle later, 8 beats;
//    o_led_data=64'hA5A5A5A5A5A5A5A5 one cycle after last beat; o_frame_update single pulse.
//  2 clients 0,1,2 request together from reset, 1-beat bursts -> grant order 0,1,2,0;
//    each grant separated by COMMIT + GAP_CYCLES; o_owner tracks grants.
//  3 client1 drops i_req after 3 beats (rows 0..2 = 8'hFF) -> o_abort pulse, o_led_data unchanged;
//    next burst writing only row 2 = 8'h3C + last -> only bits [23:16] change to 8'h3C.
//  4 client holds i_req, never asserts i_last, MAX_BEATS=16 -> o_gnt drops after 16th beat, o_abort pulse, frame unchanged.
//  5 areset high during beat 4 of a burst -> next cycle all outputs 0, state IDLE, client0 wins next arbitration.
//  6 single-beat burst row 7 = 8'hFF with last after frame 0 -> o_led_data=64'hFF00_0000_0000_0000.

Source files
------------

// File: rtl/led_frame_arbiter.sv
// Round-robin arbiter that shares the 8x8 LED frame between N_REQ clients.
// Bursts fill a shadow frame, which is swapped into the live frame only when the burst commits.
module led_frame_arbiter #(
  parameter int N_REQ      = 3,
  parameter int MAX_BEATS  = 16,
  parameter int GAP_CYCLES = 2,
  localparam int OWNER_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [3*N_REQ-1:0]   i_row_addr,
  input  logic [8*N_REQ-1:0]   i_row_data,
  input  logic [N_REQ-1:0]     i_last,
  output logic [N_REQ-1:0]     o_gnt,
  output logic [OWNER_W-1:0]   o_owner,
  output logic [63:0]          o_led_data,
  output logic                 o_frame_update,
  output logic                 o_abort
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(MAX_BEATS - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [OWNER_W-1:0] OWNER_RST = OWNER_W'(N_REQ - 1);

  typedef enum logic [2:0] {IDLE, GRANT, COMMIT, ABORT, GAP} state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [OWNER_W-1:0]  owner_q, owner_d;
  logic [63:0]         led_q, led_d;
  logic [63:0]         shadow_q, shadow_d;
  logic                update_q, update_d;
  logic                abort_q, abort_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

  logic                req_any;
  logic [OWNER_W-1:0]  win;
  int                  scan_idx;
  logic                own_req;
  logic                own_last;
  logic [2:0]          own_addr;
  logic [7:0]          own_data;
  logic                beat;
  logic                max_hit;

  assign own_req  = i_req[owner_q];
  assign own_last = i_last[owner_q];
  assign own_addr = i_row_addr[3*owner_q +: 3];
  assign own_data = i_row_data[8*owner_q +: 8];
  assign beat     = gnt_q[owner_q] & own_req;
  assign max_hit  = (beat_cnt_q == BEAT_LAST);

  // Round-robin scan starting just after the previous owner.
  always_comb begin
    req_any  = 1'b0;
    win      = owner_q;
    scan_idx = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      scan_idx = (int'(owner_q) + i) % N_REQ;
      if (!req_any && i_req[scan_idx]) begin
        req_any = 1'b1;
        win     = OWNER_W'(scan_idx);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= OWNER_RST;
      led_q      <= '0;
      shadow_q   <= '0;
      update_q   <= 1'b0;
      abort_q    <= 1'b0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      led_q      <= led_d;
      shadow_q   <= shadow_d;
      update_q   <= update_d;
      abort_q    <= abort_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = GRANT;
      GRANT: begin
        if (beat && own_last)     state_d = COMMIT;
        else if (beat && max_hit) state_d = ABORT;
        else if (!own_req)        state_d = ABORT;
      end
      COMMIT:  state_d = GAP;
      ABORT:   state_d = GAP;
      GAP:     if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    led_d      = led_q;
    shadow_d   = shadow_q;
    update_d   = 1'b0;
    abort_d    = 1'b0;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          owner_d    = win;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (beat) begin
          shadow_d[8*own_addr +: 8] = own_data;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (own_last || max_hit) gnt_d = '0;
        end else if (!own_req) begin
          gnt_d = '0;
        end
      end
      COMMIT: begin
        led_d     = shadow_q;
        update_d  = 1'b1;
        gap_cnt_d = '0;
      end
      // Roll the shadow back so a discarded burst leaves no trace in later frames.
      ABORT: begin
        shadow_d  = led_q;
        abort_d   = 1'b1;
        gap_cnt_d = '0;
      end
      GAP:     gap_cnt_d = gap_cnt_q + 1'b1;
      default: gnt_d = '0;
    endcase
  end

  assign o_gnt          = gnt_q;
  assign o_owner        = owner_q;
  assign o_led_data     = led_q;
  assign o_frame_update = update_q;
  assign o_abort        = abort_q;

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Directed bench for led_frame_arbiter: one task per scenario, inputs driven 1 time unit
// after each rising edge and registered outputs sampled at the same point.
module tb_led_frame_arbiter;

  logic        aclk;
  logic        areset;
  logic [2:0]  req;
  logic [8:0]  row_addr;
  logic [23:0] row_data;
  logic [2:0]  last;
  logic [2:0]  gnt;
  logic [1:0]  owner;
  logic [63:0] led;
  logic        upd;
  logic        abrt;

  int n_cmp  = 0;
  int n_fail = 0;

  led_frame_arbiter #(.N_REQ(3), .MAX_BEATS(16), .GAP_CYCLES(2)) dut (
    .aclk           (aclk),
    .areset         (areset),
    .i_req          (req),
    .i_row_addr     (row_addr),
    .i_row_data     (row_data),
    .i_last         (last),
    .o_gnt          (gnt),
    .o_owner        (owner),
    .o_led_data     (led),
    .o_frame_update (upd),
    .o_abort        (abrt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_client(input int k, input logic r, input logic [2:0] a,
                            input logic [7:0] d, input logic l);
    req[k]            = r;
    row_addr[3*k +: 3] = a;
    row_data[8*k +: 8] = d;
    last[k]           = l;
  endtask

  task automatic clear_inputs();
    req      = '0;
    row_addr = '0;
    row_data = '0;
    last     = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic wait_grant(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (gnt !== 3'b000) begin
        cycles = i;
        ok     = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (led !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_led: got %h want %h", led, 64'h0); end
    n_cmp++; if (gnt !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b want %b", gnt, 3'b000); end
    n_cmp++; if (owner !== 2'd2) begin n_fail++; $display("[TB] FAIL reset_owner: got %0d want %0d", owner, 2); end
    n_cmp++; if (upd !== 1'b0 || abrt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pulses: got upd=%b abort=%b want 0 0", upd, abrt); end
  endtask

  task automatic test_full_frame();
    int cyc; bit ok;
    do_reset();
    set_client(0, 1'b1, 3'd0, 8'hA5, 1'b0);
    wait_grant(cyc, ok);
    n_cmp++; if (!ok || cyc != 1) begin n_fail++; $display("[TB] FAIL frame_grant_latency: got %0d want 1", cyc); end
    n_cmp++; if (gnt !== 3'b001 || owner !== 2'd0) begin n_fail++; $display("[TB] FAIL frame_grant: got gnt=%b owner=%0d want 001 0", gnt, owner); end
    for (int r = 0; r < 8; r++) begin
      set_client(0, 1'b1, 3'(r), 8'hA5, r == 7);
      tick();
      if (r == 6) begin
        n_cmp++; if (gnt !== 3'b001 || led !== 64'h0) begin n_fail++; $display("[TB] FAIL frame_mid_burst: got gnt=%b led=%h want 001 0", gnt, led); end
      end
    end
    n_cmp++; if (gnt !== 3'b000 || upd !== 1'b0) begin n_fail++; $display("[TB] FAIL frame_after_last: got gnt=%b upd=%b want 000 0", gnt, upd); end
    set_client(0, 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    n_cmp++; if (led !== 64'hA5A5A5A5A5A5A5A5) begin n_fail++; $display("[TB] FAIL frame_commit_led: got %h want %h", led, 64'hA5A5A5A5A5A5A5A5); end
    n_cmp++; if (upd !== 1'b1) begin n_fail++; $display("[TB] FAIL frame_update_pulse: got %b want 1", upd); end
    tick();
    n_cmp++; if (upd !== 1'b0 || led !== 64'hA5A5A5A5A5A5A5A5) begin n_fail++; $display("[TB] FAIL frame_update_single: got upd=%b led=%h want 0 a5..", upd, led); end
    tick(); tick(); tick();
  endtask

  task automatic test_round_robin();
    int cyc; bit ok;
    logic [2:0] exp_gnt [4];
    exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100; exp_gnt[3] = 3'b001;
    do_reset();
    for (int k = 0; k < 3; k++) set_client(k, 1'b1, 3'(k), 8'(8'h11 * (k + 1)), 1'b1);
    for (int g = 0; g < 4; g++) begin
      wait_grant(cyc, ok);
      n_cmp++; if (!ok || cyc != ((g == 0) ? 1 : 5)) begin n_fail++; $display("[TB] FAIL rr_spacing%0d: got %0d cycles want %0d", g, cyc, (g == 0) ? 1 : 5); end
      n_cmp++; if (gnt !== exp_gnt[g]) begin n_fail++; $display("[TB] FAIL rr_gnt%0d: got %b want %b", g, gnt, exp_gnt[g]); end
      n_cmp++; if (owner !== 2'(g % 3)) begin n_fail++; $display("[TB] FAIL rr_owner%0d: got %0d want %0d", g, owner, g % 3); end
    end
    tick();
    clear_inputs();
    tick();
    n_cmp++; if (led !== 64'h0000_0000_0033_2211) begin n_fail++; $display("[TB] FAIL rr_frame: got %h want %h", led, 64'h0000_0000_0033_2211); end
    tick(); tick(); tick();
  endtask

  task automatic test_abort_drop();
    int cyc; bit ok;
    do_reset();
    set_client(0, 1'b1, 3'd5, 8'h5A, 1'b1);
    wait_grant(cyc, ok);
    tick();
    clear_inputs();
    tick(); tick(); tick(); tick();
    n_cmp++; if (led !== 64'h0000_5A00_0000_0000) begin n_fail++; $display("[TB] FAIL drop_setup_frame: got %h want %h", led, 64'h0000_5A00_0000_0000); end
    set_client(1, 1'b1, 3'd0, 8'hFF, 1'b0);
    wait_grant(cyc, ok);
    n_cmp++; if (!ok || gnt !== 3'b010) begin n_fail++; $display("[TB] FAIL drop_grant: got %b want %b", gnt, 3'b010); end
    for (int r = 0; r < 3; r++) begin
      set_client(1, 1'b1, 3'(r), 8'hFF, 1'b0);
      tick();
    end
    set_client(1, 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    n_cmp++; if (gnt !== 3'b000) begin n_fail++; $display("[TB] FAIL drop_gnt_release: got %b want 000", gnt); end
    tick();
    n_cmp++; if (abrt !== 1'b1 || upd !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_abort_pulse: got abort=%b upd=%b want 1 0", abrt, upd); end
    n_cmp++; if (led !== 64'h0000_5A00_0000_0000) begin n_fail++; $display("[TB] FAIL drop_frame_kept: got %h want %h", led, 64'h0000_5A00_0000_0000); end
    tick();
    n_cmp++; if (abrt !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_abort_single: got %b want 0", abrt); end
    set_client(1, 1'b1, 3'd2, 8'h3C, 1'b1);
    wait_grant(cyc, ok);
    n_cmp++; if (!ok || gnt !== 3'b010) begin n_fail++; $display("[TB] FAIL drop_regrant: got %b want %b", gnt, 3'b010); end
    tick();
    clear_inputs();
    tick();
    n_cmp++; if (led !== 64'h0000_5A00_003C_0000) begin n_fail++; $display("[TB] FAIL drop_partial_row: got %h want %h", led, 64'h0000_5A00_003C_0000); end
    tick(); tick(); tick();
  endtask

  task automatic test_max_beats();
    int cyc; bit ok;
    do_reset();
    set_client(2, 1'b1, 3'd0, 8'hEE, 1'b0);
    wait_grant(cyc, ok);
    n_cmp++; if (!ok || gnt !== 3'b100 || owner !== 2'd2) begin n_fail++; $display("[TB] FAIL max_grant: got gnt=%b owner=%0d want 100 2", gnt, owner); end
    for (int b = 1; b <= 16; b++) begin
      set_client(2, 1'b1, 3'((b - 1) % 8), 8'hEE, 1'b0);
      tick();
      if (b == 15) begin
        n_cmp++; if (gnt !== 3'b100) begin n_fail++; $display("[TB] FAIL max_beat15_gnt: got %b want 100", gnt); end
      end
    end
    n_cmp++; if (gnt !== 3'b000) begin n_fail++; $display("[TB] FAIL max_beat16_gnt: got %b want 000", gnt); end
    tick();
    n_cmp++; if (abrt !== 1'b1 || led !== 64'h0) begin n_fail++; $display("[TB] FAIL max_abort: got abort=%b led=%h want 1 0", abrt, led); end
    clear_inputs();
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_burst();
    int cyc; bit ok;
    do_reset();
    set_client(0, 1'b1, 3'd3, 8'h77, 1'b1);
    wait_grant(cyc, ok);
    tick();
    clear_inputs();
    tick();
    n_cmp++; if (led !== 64'h0000_0000_7700_0000) begin n_fail++; $display("[TB] FAIL rst_setup_frame: got %h want %h", led, 64'h0000_0000_7700_0000); end
    tick(); tick(); tick();
    set_client(1, 1'b1, 3'd0, 8'h11, 1'b0);
    wait_grant(cyc, ok);
    n_cmp++; if (!ok || gnt !== 3'b010) begin n_fail++; $display("[TB] FAIL rst_grant: got %b want 010", gnt); end
    for (int r = 0; r < 3; r++) begin
      set_client(1, 1'b1, 3'(r), 8'h11, 1'b0);
      tick();
    end
    set_client(1, 1'b1, 3'd3, 8'h11, 1'b0);
    areset = 1'b1;
    tick();
    n_cmp++; if (gnt !== 3'b000 || led !== 64'h0 || upd !== 1'b0 || abrt !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_outputs: got gnt=%b led=%h upd=%b abort=%b want 0", gnt, led, upd, abrt); end
    n_cmp++; if (owner !== 2'd2) begin n_fail++; $display("[TB] FAIL rst_owner: got %0d want 2", owner); end
    areset = 1'b0;
    set_client(0, 1'b1, 3'd0, 8'h00, 1'b0);
    wait_grant(cyc, ok);
    n_cmp++; if (!ok || cyc != 1 || gnt !== 3'b001) begin n_fail++; $display("[TB] FAIL rst_first_winner: got gnt=%b after %0d want 001 after 1", gnt, cyc); end
    clear_inputs();
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_single_beat();
    do_reset();
    set_client(0, 1'b1, 3'd7, 8'hFF, 1'b1);
    tick();
    n_cmp++; if (gnt !== 3'b001) begin n_fail++; $display("[TB] FAIL single_grant: got %b want 001", gnt); end
    tick();
    n_cmp++; if (gnt !== 3'b000 || led !== 64'h0) begin n_fail++; $display("[TB] FAIL single_pre_commit: got gnt=%b led=%h want 000 0", gnt, led); end
    clear_inputs();
    tick();
    n_cmp++; if (led !== 64'hFF00_0000_0000_0000 || upd !== 1'b1) begin n_fail++; $display("[TB] FAIL single_commit: got led=%h upd=%b want %h 1", led, upd, 64'hFF00_0000_0000_0000); end
    tick(); tick(); tick();
  endtask

  initial begin
    areset = 1'b1;
    clear_inputs();
    test_reset();
    test_full_frame();
    test_round_robin();
    test_abort_drop();
    test_max_beats();
    test_reset_mid_burst();
    test_single_beat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
